// File: rtl/monkey_range_scan.sv
// Per-frame range scan of the 8 monkey slots against the latched bloon position.
// Optional per-slot fire cooldown enabled by defining MONKEY_COOLDOWN_EN.
module monkey_range_scan #(
  parameter int unsigned RANGE    = 64,
  parameter int unsigned COOLDOWN = 30
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [9:0]  i_bloon_x,
  input  logic [9:0]  i_bloon_y,
  input  logic        i_bloon_valid,
  output logic [2:0]  o_rd_sel,
  input  logic [19:0] i_monkey_entry,
  output logic        o_busy,
  output logic        o_fire,
  output logic [2:0]  o_fire_slot,
  output logic [7:0]  o_hit_mask,
  output logic        o_done
);

  localparam logic [20:0] RangeSq = 21'(RANGE * RANGE);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_slot;
  logic [9:0]  r_bloon_x, r_bloon_y;
  logic        r_bloon_valid;
  logic        r_fire;
  logic [2:0]  r_fire_slot;
  logic [7:0]  r_acc;
  logic [7:0]  r_hit_mask;

  logic        w_start_acc;
  logic [9:0]  w_mx, w_my, w_dx, w_dy;
  logic [19:0] w_dx_sq, w_dy_sq;
  logic [20:0] w_sum;
  logic        w_in_range;
  logic        w_fire_now;

  assign w_start_acc = (r_state == StIdle) && i_start;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StScan;
      StScan:  if (r_slot == 3'd7) w_state_next = StFlush;
      StFlush: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy      = (r_state == StScan) || (r_state == StFlush);
    o_done      = (r_state == StDone);
    o_rd_sel    = r_slot;
    o_fire      = r_fire;
    o_fire_slot = r_fire_slot;
    o_hit_mask  = r_hit_mask;
  end

  // Squared-distance check on the entry currently selected by r_slot
  always_comb begin
    w_mx       = i_monkey_entry[19:10];
    w_my       = i_monkey_entry[9:0];
    w_dx       = (w_mx >= r_bloon_x) ? (w_mx - r_bloon_x) : (r_bloon_x - w_mx);
    w_dy       = (w_my >= r_bloon_y) ? (w_my - r_bloon_y) : (r_bloon_y - w_my);
    w_dx_sq    = {10'd0, w_dx} * {10'd0, w_dx};
    w_dy_sq    = {10'd0, w_dy} * {10'd0, w_dy};
    w_sum      = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
    w_in_range = r_bloon_valid && (i_monkey_entry != 20'h0) && (w_sum <= RangeSq);
  end

`ifdef MONKEY_COOLDOWN_EN
  localparam logic [4:0] CdInit = 5'(COOLDOWN);

  logic [4:0] r_cd [8];

  assign w_fire_now = w_in_range && (r_cd[r_slot] == 5'd0);

  // Counters only move on their own slot visit, including empty slots
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_cd[i] <= 5'd0;
    end else if (r_state == StScan) begin
      if (w_fire_now)                r_cd[r_slot] <= CdInit;
      else if (r_cd[r_slot] != 5'd0) r_cd[r_slot] <= r_cd[r_slot] - 5'd1;
    end
  end
`else
  assign w_fire_now = w_in_range;
`endif

  // Scan datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot        <= 3'd0;
      r_bloon_x     <= 10'd0;
      r_bloon_y     <= 10'd0;
      r_bloon_valid <= 1'b0;
      r_fire        <= 1'b0;
      r_fire_slot   <= 3'd0;
      r_acc         <= 8'd0;
      r_hit_mask    <= 8'd0;
    end else begin
      r_fire      <= 1'b0;
      r_fire_slot <= 3'd0;
      if (w_start_acc) begin
        r_bloon_x     <= i_bloon_x;
        r_bloon_y     <= i_bloon_y;
        r_bloon_valid <= i_bloon_valid;
        r_slot        <= 3'd0;
        r_acc         <= 8'd0;
      end
      if (r_state == StScan) begin
        r_fire      <= w_fire_now;
        r_fire_slot <= w_fire_now ? r_slot : 3'd0;
        if (w_fire_now) r_acc[r_slot] <= 1'b1;
        if (r_slot != 3'd7) r_slot <= r_slot + 3'd1;
      end
      // Slot 7's result lands in r_acc at the SCAN->FLUSH edge, so publish one edge later
      if (r_state == StFlush) r_hit_mask <= r_acc;
      if (r_state == StDone)  r_slot     <= 3'd0;
    end
  end

endmodule

// File: tb/tb_monkey_range_scan.sv
// Scoreboard bench for monkey_range_scan: stimulus queues expected Fire/Done events,
// a negedge monitor pops and compares them. Honours MONKEY_COOLDOWN_EN for the T6 check.
module tb_monkey_range_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  bx = '0, by = '0;
  logic        bv = 1'b0;
  logic [2:0]  rd_sel;
  logic [19:0] entry;
  logic        busy, fire, done;
  logic [2:0]  fire_slot;
  logic [7:0]  hit_mask;

  logic [19:0] mem [8];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct { int cyc; int slot; } fire_t;
  typedef struct { int cyc; int mask; } done_t;
  fire_t fire_q[$];
  done_t done_q[$];

  assign entry = mem[rd_sel];

  monkey_range_scan dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_bloon_x      (bx),
    .i_bloon_y      (by),
    .i_bloon_valid  (bv),
    .o_rd_sel       (rd_sel),
    .i_monkey_entry (entry),
    .o_busy         (busy),
    .o_fire         (fire),
    .o_fire_slot    (fire_slot),
    .o_hit_mask     (hit_mask),
    .o_done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every Fire/Done the DUT presents against the queues
  always @(negedge clk) begin
    if (fire) begin
      if (fire_q.size() == 0) chk("unexpected_fire_slot", int'(fire_slot), -1);
      else begin
        fire_t f;
        f = fire_q.pop_front();
        chk("fire_cycle", cyc, f.cyc);
        chk("fire_slot", int'(fire_slot), f.slot);
      end
    end else if (fire_slot != 3'd0) begin
      chk("fire_slot_idle", int'(fire_slot), 0);
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done_mask", int'(hit_mask), -1);
      else begin
        done_t d;
        d = done_q.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_hit_mask", int'(hit_mask), d.mask);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 20'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse Start at the next edge; k = cyc value right after the accepting edge.
  task automatic start_scan(input int x, input int y, input logic v, input logic [7:0] mask,
                            input bit push_done, output int k);
    @(negedge clk);
    bx = 10'(x);
    by = 10'(y);
    bv = v;
    start = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) fire_q.push_back('{cyc: k + 1 + i, slot: i});
    end
    if (push_done) done_q.push_back('{cyc: k + 9, mask: int'(mask)});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks a scan from the negedge after acceptance checking Busy and RdSel.
  task automatic wait_scan(input int k);
    for (int j = 0; j < 10; j++) begin
      chk("busy_scan", int'(busy), (j <= 8) ? 1 : 0);
      if (j <= 8) chk("rd_sel_scan", int'(rd_sel), (j < 8) ? j : 7);
      @(negedge clk);
    end
    chk("busy_idle", int'(busy), 0);
    chk("rd_sel_idle", int'(rd_sel), 0);
    chk("scan_end_cycle", cyc, k + 10);
  endtask

  task automatic scan(input int x, input int y, input logic v, input logic [7:0] mask);
    int k;
    start_scan(x, y, v, mask, 1'b1, k);
    wait_scan(k);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++) mem[i] = 20'h0;

    // T1: reset state, empty register file never hits (even bloon near origin)
    do_reset();
    chk("rst_rd_sel", int'(rd_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fire", int'(fire), 0);
    chk("rst_fire_slot", int'(fire_slot), 0);
    chk("rst_hit_mask", int'(hit_mask), 0);
    chk("rst_done", int'(done), 0);
    scan(100, 100, 1'b1, 8'h00);
    scan(0, 5, 1'b1, 8'h00);

    // T2: dx40 dy48 -> 3904 hit; (150,150) -> 5000 miss
    do_reset();
    mem[3] = {10'd100, 10'd100};
    scan(140, 148, 1'b1, 8'h08);
    scan(150, 150, 1'b1, 8'h00);

    // T3: inclusive boundary at exactly RANGE^2
    do_reset();
    mem[0] = {10'd200, 10'd200};
    scan(264, 200, 1'b1, 8'h01);
    scan(265, 200, 1'b1, 8'h00);
    scan(200, 136, 1'b1, 8'h01);

    // T4: slots 0 and 7 in range, gated by BloonValid
    do_reset();
    mem[0] = {10'd100, 10'd100};
    mem[7] = {10'd130, 10'd120};
    scan(110, 110, 1'b0, 8'h00);
    scan(110, 110, 1'b1, 8'h81);

    // T5a: Start during scan is ignored; exactly one Done
    do_reset();
    mem[0] = {10'd300, 10'd300};
    mem[1] = {10'd500, 10'd500};
    start_scan(300, 300, 1'b1, 8'h01, 1'b1, k);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_hit_mask", int'(hit_mask), 1);
    repeat (14) @(negedge clk);

    // T5b: reset mid-scan aborts without Done; fire before reset still seen
    start_scan(500, 500, 1'b1, 8'h02, 1'b0, k);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_rd_sel", int'(rd_sel), 0);
    chk("t5_rst_hit_mask", int'(hit_mask), 0);
    repeat (14) @(negedge clk);
    scan(300, 300, 1'b1, 8'h01);

    // T6: slot 2 in range for 32 consecutive scans
    do_reset();
    mem[2] = {10'd400, 10'd400};
    for (int s = 1; s <= 32; s++) begin
      logic [7:0] m;
`ifdef MONKEY_COOLDOWN_EN
      m = (s == 1 || s == 32) ? 8'h04 : 8'h00;
`else
      m = 8'h04;
`endif
      start_scan(400, 410, 1'b1, m, 1'b1, k);
      repeat (10) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("fire_q_drained", fire_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
